// File: rtl/row_bias_pkg.sv
// Shared constants, LFSR parameters and FSM encoding for the per-row value responder.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

package row_bias_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Index width for a row of len values; never below 1 bit.
    function automatic int unsigned idx_w(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    typedef enum logic [2:0] {
        S_DRAW  = 3'b001,
        S_SWAP  = 3'b010,
        S_READY = 3'b100
    } state_t;

endpackage

// File: rtl/row_bias_lfsr16.sv
// 16-bit Galois LFSR, free-running whenever reset is low.
module lfsr16
    import row_bias_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clock,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    // An all-zero seed would lock up the register.
    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? DEFAULT_SEED : SEED;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/row_bias.sv
// Row responder: holds a random permutation of one-hot values and maps the OR'ed tile request through it.
module row_bias
    import row_bias_pkg::*;
#(
    parameter int unsigned       LEN  = `GRID_LEN,
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           reshuffle,
    input  logic           rq_valtotry,
    input  logic [LEN-1:0] biasidx,
    output logic [LEN-1:0] valtotry,
    output logic           ready
);

    localparam int unsigned     IDXW  = idx_w(LEN);
    localparam logic [IDXW-1:0] I_TOP = IDXW'(LEN - 1);

    state_t          state, state_next;
    logic [IDXW-1:0] i, i_next;
    logic [IDXW-1:0] j, j_next;
    logic [IDXW-1:0] draw;
    logic            do_swap;
    logic [LEN-1:0]  perm [LEN];
    logic [LEN-1:0]  lookup;
    logic [LFSR_W-1:0] lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr)
    );

    assign draw = lfsr[IDXW-1:0];

    // Fisher-Yates with rejection sampling; reshuffle restarts from the current perm.
    always_comb begin
        state_next = state;
        i_next     = i;
        j_next     = j;
        do_swap    = 1'b0;
        case (state)
            S_DRAW: begin
                if (draw <= i) begin
                    j_next     = draw;
                    state_next = S_SWAP;
                end
            end
            S_SWAP: begin
                do_swap = 1'b1;
                if (i == IDXW'(1)) begin
                    state_next = S_READY;
                end else begin
                    i_next     = i - IDXW'(1);
                    state_next = S_DRAW;
                end
            end
            S_READY: state_next = S_READY;
            default: state_next = S_DRAW;
        endcase
        if (reshuffle) begin
            state_next = S_DRAW;
            i_next     = I_TOP;
            do_swap    = 1'b0;
        end
    end

    // OR of selected entries; multi-hot requests simply merge.
    always_comb begin
        lookup = '0;
        for (int k = 0; k < LEN; k++) begin
            if (biasidx[k]) lookup = lookup | perm[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_DRAW;
            i        <= I_TOP;
            j        <= '0;
            ready    <= 1'b0;
            valtotry <= '0;
        end else begin
            state <= state_next;
            i     <= i_next;
            j     <= j_next;
            ready <= (state_next == S_READY);
            // A half-shuffled row answers zero so no tile loads a stale value.
            if (rq_valtotry) valtotry <= ready ? lookup : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LEN; k++) perm[k] <= LEN'(1) << k;
        end else if (do_swap) begin
            perm[i] <= perm[j];
            perm[j] <= perm[i];
        end
    end

endmodule

// File: tb/tb_row_bias.sv
// Scoreboard bench for row_bias: a cycle-counted Fisher-Yates model predicts every permutation.
`timescale 1ns/1ps
module tb_row_bias;
    import row_bias_pkg::*;

    localparam int LEN = 9;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int DRAW_MOD = 2 ** $clog2(LEN);
    localparam logic [LEN-1:0] ALL = '1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           reshuffle = 1'b0;
    logic           rq_valtotry = 1'b0;
    logic [LEN-1:0] biasidx = '0;
    logic [LEN-1:0] valtotry;
    logic           ready;

    row_bias #(.LEN(LEN), .SEED(SEED)) dut (
        .clock       (clock),
        .reset       (reset),
        .reshuffle   (reshuffle),
        .rq_valtotry (rq_valtotry),
        .biasidx     (biasidx),
        .valtotry    (valtotry),
        .ready       (ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;
    logic           storm = 1'b0;
    logic [LEN-1:0] sb_q [$];
    logic [LEN-1:0] mon_exp;
    logic [LEN-1:0] model_perm [LEN];
    logic [LEN-1:0] resp [LEN];
    logic [LEN-1:0] first [LEN];
    logic [LEN-1:0] old_resp [LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge index since reset release; the LFSR holds step^n(SEED) at edge n.
    always @(posedge clock or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Monitor: every request edge with a pending expectation is checked one cycle later.
    always @(posedge clock) begin
        if (!reset && rq_valtotry && sb_q.size() > 0) begin
            #1;
            mon_exp = sb_q.pop_front();
            check("response", valtotry, mon_exp);
        end
    end

    // Permutation must hold every cycle, including mid-shuffle; responses stay zero/one-hot.
    always @(negedge clock) begin : perm_chk
        logic [LEN-1:0] acc;
        int bad;
        if (!reset) begin
            acc = '0;
            bad = 0;
            for (int k = 0; k < LEN; k++) begin
                acc = acc | dut.perm[k];
                if (!$onehot(dut.perm[k])) bad++;
            end
            check("perm_invariant_or", acc, ALL);
            check("perm_invariant_onehot", bad, 0);
            if (storm) check("valtotry_onehot0", $onehot0(valtotry), 1);
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Shuffle model_perm starting with a DRAW at edge 'start'; 'done' is the edge of the last swap.
    task automatic model_shuffle(input int start, output int done);
        logic [15:0]    l;
        logic [LEN-1:0] t;
        int c;
        int jj;
        l = SEED;
        for (int n = 0; n < start; n++) l = lfsr_step(l);
        c = start;
        done = start;
        for (int ii = LEN - 1; ii >= 1; ii--) begin
            while (int'(l) % DRAW_MOD > ii) begin
                l = lfsr_step(l);
                c++;
            end
            jj = int'(l) % DRAW_MOD;
            l = lfsr_step(l);
            c++;
            t = model_perm[ii];
            model_perm[ii] = model_perm[jj];
            model_perm[jj] = t;
            done = c;
            l = lfsr_step(l);
            c++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < LEN; k++) model_perm[k] = LEN'(1) << k;
    endtask

    // Bounded wait for ready; exp_edge < 0 skips the timing comparison.
    task automatic wait_ready(input string name, input int exp_edge);
        int k = 0;
        while (!ready && k < 256) begin
            @(negedge clock);
            k++;
        end
        if (!ready) check(name, 0, 1);
        else if (exp_edge >= 0) check(name, edge_n, exp_edge + 1);
    endtask

    task automatic query(input logic [LEN-1:0] b, input logic [LEN-1:0] exp, input bit use_sb,
                         output logic [LEN-1:0] act);
        @(negedge clock);
        rq_valtotry = 1'b1;
        biasidx     = b;
        if (use_sb) sb_q.push_back(exp);
        @(posedge clock);
        #2 act = valtotry;
        @(negedge clock);
        rq_valtotry = 1'b0;
        biasidx     = '0;
    endtask

    task automatic query_all(input bit use_sb);
        for (int k = 0; k < LEN; k++) query(LEN'(1) << k, model_perm[k], use_sb, resp[k]);
    endtask

    task automatic check_resp_perm(input string name);
        logic [LEN-1:0] acc = '0;
        int bad = 0;
        for (int k = 0; k < LEN; k++) begin
            acc = acc | resp[k];
            if (!$onehot(resp[k])) bad++;
        end
        check({name, "_or"}, acc, ALL);
        check({name, "_onehot"}, bad, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LEN-1:0] act;
        int done;
        int start;
        int diff;
        int k;

        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", ready, 0);
        check("reset_valtotry", valtotry, 0);

        // First shuffle after reset release.
        model_reset();
        model_shuffle(0, done);
        @(negedge clock);
        reset = 1'b0;
        query(LEN'(1), '0, 1'b1, act);
        wait_ready("ready_time_first", done);
        query_all(1'b1);
        for (int n = 0; n < LEN; n++) first[n] = resp[n];
        check_resp_perm("first_perm");

        // Latency and hold.
        query(LEN'(4), model_perm[2], 1'b1, act);
        repeat (5) begin
            @(negedge clock);
            check("hold", valtotry, model_perm[2]);
        end

        // Idle index and multi-hot boundary cases.
        query('0, '0, 1'b1, act);
        query(LEN'(3), model_perm[0] | model_perm[1], 1'b1, act);
        query(LEN'(9'h180), model_perm[7] | model_perm[8], 1'b1, act);

        // Reshuffle and request on the same edge: answer comes from the old perm.
        for (int n = 0; n < LEN; n++) old_resp[n] = first[n];
        @(negedge clock);
        reshuffle   = 1'b1;
        rq_valtotry = 1'b1;
        biasidx     = LEN'(8);
        sb_q.push_back(model_perm[3]);
        start = edge_n + 1;
        @(negedge clock);
        reshuffle   = 1'b0;
        rq_valtotry = 1'b0;
        biasidx     = '0;
        check("ready_drop", ready, 0);
        model_shuffle(start, done);
        wait_ready("ready_time_reshuffle", done);
        query_all(1'b1);
        check_resp_perm("second_perm");
        diff = 0;
        for (int n = 0; n < LEN; n++) if (resp[n] != old_resp[n]) diff++;
        check("perm_changed", diff > 0, 1);

        // Async reset mid-SWAP.
        @(negedge clock);
        reshuffle = 1'b1;
        @(negedge clock);
        reshuffle = 1'b0;
        k = 0;
        while (dut.state != S_SWAP && k < 256) begin
            @(negedge clock);
            k++;
        end
        check("reached_swap", dut.state == S_SWAP, 1);
        reset = 1'b1;
        #1;
        check("async_reset_ready", ready, 0);
        check("async_reset_valtotry", valtotry, 0);
        model_reset();
        model_shuffle(0, done);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_ready("ready_time_after_reset", done);
        query_all(1'b1);
        for (int n = 0; n < LEN; n++) check("repeat_perm", resp[n], first[n]);

        // Random reshuffles with random legal requests.
        storm = 1'b1;
        repeat (1000) begin
            @(negedge clock);
            reshuffle   = ($urandom_range(0, 19) == 0);
            rq_valtotry = $urandom_range(0, 1) == 1;
            biasidx     = ($urandom_range(0, 3) == 0) ? '0 : LEN'(1) << $urandom_range(0, LEN - 1);
        end
        @(negedge clock);
        reshuffle   = 1'b0;
        rq_valtotry = 1'b0;
        biasidx     = '0;
        @(negedge clock);
        reshuffle = 1'b1;
        @(negedge clock);
        reshuffle = 1'b0;
        check("ready_drop_storm", ready, 0);
        wait_ready("ready_after_storm", -1);
        query_all(1'b0);
        check_resp_perm("storm_perm");
        storm = 1'b0;

        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
